// File: rtl/pulse_dispatcher.sv
// Pulse dispatcher: pops one pulse entry at a time from a FWFT FIFO, waits for its start
// time on the global counter, then streams per-sample phase/amp/envelope words downstream.
module pulse_dispatcher #(
    parameter int FREQ_W     = 32,
    parameter int PHASE_W    = 16,
    parameter int AMP_W      = 16,
    parameter int TSTART_W   = 32,
    parameter int TLEN_W     = 16,
    parameter int ENV_ADDR_W = 10,
    parameter int ACC_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [TSTART_W-1:0]   counter,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [FREQ_W-1:0]     fifo_freq,
    input  logic [PHASE_W-1:0]    fifo_phase,
    input  logic [AMP_W-1:0]      fifo_amp,
    input  logic [TSTART_W-1:0]   fifo_tstart,
    input  logic [TLEN_W-1:0]     fifo_tlen,
    input  logic [ENV_ADDR_W-1:0] fifo_env_addr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PHASE_W-1:0]    m_phase,
    output logic [AMP_W-1:0]      m_amp,
    output logic [ENV_ADDR_W-1:0] m_env_addr,
    output logic                  m_last,
    output logic                  busy,
    output logic                  late_flag,
    output logic [15:0]           pulses_done,
    output logic [1:0]            dbg_state
);

    // Stream handshake: a sample transfers on any cycle with m_valid && m_ready; while
    // m_valid is high and m_ready low every m_* output holds its value.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    localparam logic [TLEN_W-1:0] TLEN_ONE = TLEN_W'(1);

    state_t                  r_state;
    logic [FREQ_W-1:0]       r_freq;
    logic [PHASE_W-1:0]      r_phase;
    logic [AMP_W-1:0]        r_amp;
    logic [TSTART_W-1:0]     r_tstart;
    logic [TLEN_W-1:0]       r_tlen;
    logic [ENV_ADDR_W-1:0]   r_env_base;
    logic [ACC_W-1:0]        r_acc;
    logic [TLEN_W-1:0]       r_idx;
    logic                    r_valid;
    logic                    r_late;
    logic                    r_wait_first;
    logic [15:0]             r_done;

    logic                    w_pop;
    logic signed [TSTART_W-1:0] w_delta;
    logic                    w_due;
    logic                    w_late_now;
    logic [TLEN_W-1:0]       w_tlen_m1;
    logic                    w_last;
    logic                    w_accept;
    logic [ACC_W-1:0]        w_acc_init;
    logic [ENV_ADDR_W-1:0]   w_idx_env;

    // Reset gates the pop so a pending FIFO head is never consumed during reset.
    assign w_pop      = (r_state == ST_IDLE) && enable && !fifo_empty && !rst;
    assign w_delta    = counter - r_tstart;
    assign w_due      = !w_delta[TSTART_W-1];
    assign w_late_now = w_due && (w_delta != '0);
    assign w_tlen_m1  = r_tlen - TLEN_ONE;
    assign w_last     = r_valid && (r_idx == w_tlen_m1);
    assign w_accept   = r_valid && m_ready;
    assign w_acc_init = ACC_W'(r_phase) << (ACC_W - PHASE_W);
    assign w_idx_env  = ENV_ADDR_W'(r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_freq       <= '0;
            r_phase      <= '0;
            r_amp        <= '0;
            r_tstart     <= '0;
            r_tlen       <= '0;
            r_env_base   <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_valid      <= 1'b0;
            r_late       <= 1'b0;
            r_wait_first <= 1'b0;
            r_done       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_freq       <= fifo_freq;
                        r_phase      <= fifo_phase;
                        r_amp        <= fifo_amp;
                        r_tstart     <= fifo_tstart;
                        r_tlen       <= fifo_tlen;
                        r_env_base   <= fifo_env_addr;
                        r_wait_first <= 1'b1;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_wait_first <= 1'b0;
                    // Lateness is judged only on the first WAIT cycle; later cycles reach d == 0 exactly.
                    if (r_wait_first && w_late_now) begin
                        r_late <= 1'b1;
                    end
                    if (r_tlen == '0) begin
                        r_state <= ST_IDLE;
                    end else if (w_due) begin
                        r_state <= ST_PLAY;
                        r_valid <= 1'b1;
                        r_acc   <= w_acc_init;
                        r_idx   <= '0;
                    end
                end
                ST_PLAY: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_done  <= r_done + 16'd1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_acc <= r_acc + ACC_W'(r_freq);
                            r_idx <= r_idx + TLEN_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en  = w_pop;
    assign m_valid     = r_valid;
    assign m_phase     = r_acc[ACC_W-1 -: PHASE_W];
    assign m_amp       = r_amp;
    assign m_env_addr  = r_env_base + w_idx_env;
    assign m_last      = w_last;
    assign busy        = (r_state != ST_IDLE);
    assign late_flag   = r_late;
    assign pulses_done = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pulse_dispatcher.sv
// Bench for pulse_dispatcher: FIFO model feeding entries, sample scoreboard fed at pop time,
// table of single-pulse vectors plus hand sequences for zero length, enable and mid-pulse reset.
module tb_pulse_dispatcher;

    localparam int PHASE_W    = 16;
    localparam int AMP_W      = 16;
    localparam int ENV_ADDR_W = 10;
    localparam int ACC_W      = 32;
    localparam int SB_W       = PHASE_W + AMP_W + ENV_ADDR_W + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] counter;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_freq;
    logic [15:0] fifo_phase;
    logic [15:0] fifo_amp;
    logic [31:0] fifo_tstart;
    logic [15:0] fifo_tlen;
    logic [9:0]  fifo_env_addr;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_phase;
    logic [15:0] m_amp;
    logic [9:0]  m_env_addr;
    logic        m_last;
    logic        busy;
    logic        late_flag;
    logic [15:0] pulses_done;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    pulse_dispatcher dut (
        .clk(clk), .rst(rst), .enable(enable), .counter(counter),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_freq(fifo_freq), .fifo_phase(fifo_phase), .fifo_amp(fifo_amp),
        .fifo_tstart(fifo_tstart), .fifo_tlen(fifo_tlen), .fifo_env_addr(fifo_env_addr),
        .m_valid(m_valid), .m_ready(m_ready), .m_phase(m_phase), .m_amp(m_amp),
        .m_env_addr(m_env_addr), .m_last(m_last), .busy(busy), .late_flag(late_flag),
        .pulses_done(pulses_done), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [31:0] freq;
        logic [15:0] phase;
        logic [15:0] amp;
        logic [31:0] tstart;
        logic [15:0] tlen;
        logic [9:0]  env;
    } entry_t;

    typedef struct {
        entry_t      e;
        logic [31:0] cnt0;
        logic [3:0]  ready_pat;
        logic        exp_late;
        logic        exp_play;
        logic [31:0] exp_first;
        logic [15:0] exp_done;
    } vec_t;

    entry_t          fifo_q[$];
    logic [SB_W-1:0] exp_q[$];
    vec_t            vec[8];

    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc;
    logic [3:0]      ready_pat;
    logic            popped;
    int              n_pops;
    int              n_accept;
    logic            seen_valid;
    logic [31:0]     first_cnt;
    logic            prev_stall;
    logic [SB_W-1:0] saved;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic entry_t mk_entry(input logic [31:0] freq, input logic [15:0] phase,
                                        input logic [15:0] amp, input logic [31:0] tstart,
                                        input logic [15:0] tlen, input logic [9:0] env);
        entry_t e;
        e.freq = freq; e.phase = phase; e.amp = amp;
        e.tstart = tstart; e.tlen = tlen; e.env = env;
        return e;
    endfunction

    function automatic vec_t mk_vec(input entry_t e, input logic [31:0] cnt0, input logic [3:0] pat,
                                    input logic late, input logic play, input logic [31:0] first,
                                    input logic [15:0] done);
        vec_t v;
        v.e = e; v.cnt0 = cnt0; v.ready_pat = pat; v.exp_late = late;
        v.exp_play = play; v.exp_first = first; v.exp_done = done;
        return v;
    endfunction

    // Reference sample stream for one entry: phase is the top of an ACC_W accumulator.
    task automatic push_expected(input entry_t e);
        logic [ACC_W-1:0]      acc;
        logic [ENV_ADDR_W-1:0] ea;
        logic                  lst;
        acc = ACC_W'(e.phase) << (ACC_W - PHASE_W);
        for (int i = 0; i < int'(e.tlen); i++) begin
            ea  = e.env + 10'(i);
            lst = (i == int'(e.tlen) - 1);
            exp_q.push_back({acc[ACC_W-1 -: PHASE_W], e.amp, ea, lst});
            acc = acc + e.freq;
        end
    endtask

    task automatic drive_head();
        if (fifo_q.size() > 0) begin
            fifo_empty    = 1'b0;
            fifo_freq     = fifo_q[0].freq;
            fifo_phase    = fifo_q[0].phase;
            fifo_amp      = fifo_q[0].amp;
            fifo_tstart   = fifo_q[0].tstart;
            fifo_tlen     = fifo_q[0].tlen;
            fifo_env_addr = fifo_q[0].env;
        end else begin
            fifo_empty    = 1'b1;
            fifo_freq     = '0;
            fifo_phase    = '0;
            fifo_amp      = '0;
            fifo_tstart   = '0;
            fifo_tlen     = '0;
            fifo_env_addr = '0;
        end
    endtask

    task automatic sample();
        if (rst) begin
            check("rd_en_during_rst", fifo_rd_en, 0);
            prev_stall = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                check("rd_en_only_nonempty", fifo_empty, 0);
                n_pops++;
                if (!fifo_empty) begin
                    push_expected(fifo_q[0]);
                    popped = 1'b1;
                end
            end
            if (prev_stall) begin
                check("stall_hold", {m_valid, m_phase, m_amp, m_env_addr, m_last}, {1'b1, saved});
            end
            if (m_valid && !seen_valid) begin
                seen_valid = 1'b1;
                first_cnt  = counter;
            end
            if (m_valid && m_ready) begin
                n_accept++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sample_extra: got phase 0x%0h env 0x%0h, none expected", m_phase, m_env_addr);
                end else begin
                    check("sample", {m_phase, m_amp, m_env_addr, m_last}, exp_q.pop_front());
                end
            end
            prev_stall = m_valid && !m_ready;
            saved      = {m_phase, m_amp, m_env_addr, m_last};
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (popped) fifo_q.delete(0);
        popped  = 1'b0;
        counter = counter + 32'd1;
        cyc++;
        m_ready = ready_pat[cyc % 4];
        drive_head();
    endtask

    task automatic clear_monitor();
        n_pops     = 0;
        n_accept   = 0;
        seen_valid = 1'b0;
        first_cnt  = '0;
        prev_stall = 1'b0;
        cyc        = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_late", late_flag, 0);
        check("rst_done", pulses_done, 0);
        check("rst_state", dbg_state, 0);
        check("rst_phase_last", {m_phase, m_last}, 0);
        step();
        rst = 1'b0;
        exp_q.delete();
        clear_monitor();
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while (!((fifo_q.size() == 0 || !enable) && !busy && exp_q.size() == 0) && k < budget) begin
            step();
            k++;
        end
        check("run_timeout", (k >= budget), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; counter = '0; m_ready = 1'b1; ready_pat = 4'hF;
        popped = 1'b0;
        clear_monitor();
        drive_head();

        vec[0] = mk_vec(mk_entry(32'h0100_0000, 16'h4000, 16'h7FFF, 32'd100, 16'd4, 10'h3FE),
                        32'd90, 4'b1111, 1'b0, 1'b1, 32'd101, 16'd1);
        vec[1] = mk_vec(mk_entry(32'h0100_0000, 16'h4000, 16'h7FFF, 32'd100, 16'd4, 10'h3FE),
                        32'd90, 4'b1001, 1'b0, 1'b1, 32'd101, 16'd1);
        vec[2] = mk_vec(mk_entry(32'h0010_0000, 16'h1000, 16'h0100, 32'd50, 16'd5, 10'h010),
                        32'd60, 4'b1111, 1'b1, 1'b1, 32'd62, 16'd1);
        vec[3] = mk_vec(mk_entry(32'h0040_0000, 16'hFFF0, 16'h00FF, 32'd2, 16'd3, 10'h3FF),
                        32'hFFFF_FFFE, 4'b1111, 1'b0, 1'b1, 32'd3, 16'd1);
        vec[4] = mk_vec(mk_entry(32'h0100_0000, 16'h2000, 16'h0001, 32'd200, 16'd0, 10'h000),
                        32'd190, 4'b1111, 1'b0, 1'b0, 32'd0, 16'd0);
        vec[5] = mk_vec(mk_entry(32'hFFFF_0000, 16'h0001, 16'h1234, 32'd20, 16'd6, 10'h000),
                        32'd10, 4'b0101, 1'b0, 1'b1, 32'd21, 16'd1);
        vec[6] = mk_vec(mk_entry(32'h0000_8000, 16'h0000, 16'h8000, 32'd40, 16'd4, 10'h100),
                        32'd40, 4'b1111, 1'b1, 1'b1, 32'd42, 16'd1);
        vec[7] = mk_vec(mk_entry(32'h0000_8000, 16'h0000, 16'h8000, 32'd40, 16'd4, 10'h100),
                        32'd39, 4'b0011, 1'b0, 1'b1, 32'd41, 16'd1);

        for (int r = 0; r < 8; r++) begin
            ready_pat = 4'hF;
            do_reset();
            counter   = vec[r].cnt0;
            ready_pat = vec[r].ready_pat;
            m_ready   = ready_pat[0];
            fifo_q.push_back(vec[r].e);
            drive_head();
            run_until_idle(300);
            check("seen_valid", seen_valid, vec[r].exp_play);
            check("first_valid_cnt", first_cnt, vec[r].exp_first);
            check("late_flag", late_flag, vec[r].exp_late);
            check("pulses_done", pulses_done, vec[r].exp_done);
            check("accept_count", n_accept, vec[r].e.tlen);
            check("pop_count", n_pops, 1);
        end

        // Zero-length entry followed by a normal one.
        ready_pat = 4'hF;
        do_reset();
        counter = 32'd300;
        fifo_q.push_back(mk_entry(32'h0100_0000, 16'h0000, 16'h0001, 32'd310, 16'd0, 10'h000));
        fifo_q.push_back(mk_entry(32'h0200_0000, 16'h0000, 16'h5555, 32'd320, 16'd3, 10'h200));
        drive_head();
        run_until_idle(100);
        check("zl_pops", n_pops, 2);
        check("zl_accepts", n_accept, 3);
        check("zl_done", pulses_done, 1);
        check("zl_first", first_cnt, 321);
        check("zl_late", late_flag, 0);

        // Enable low blocks pops; dropping it mid-pulse lets the pulse finish.
        do_reset();
        enable  = 1'b0;
        counter = 32'd1000;
        fifo_q.push_back(mk_entry(32'h0080_0000, 16'h0100, 16'h0AAA, 32'd1005, 16'd4, 10'h0F0));
        drive_head();
        repeat (10) step();
        check("en_no_pop", n_pops, 0);
        check("en_idle", busy, 0);
        enable = 1'b1;
        for (int k = 0; k < 5 && n_pops == 0; k++) step();
        check("en_pop", n_pops, 1);
        enable = 1'b0;
        fifo_q.push_back(mk_entry(32'h0080_0000, 16'h0000, 16'h0BBB, 32'd1020, 16'd2, 10'h000));
        drive_head();
        run_until_idle(100);
        repeat (5) step();
        check("en_done", pulses_done, 1);
        check("en_accepts", n_accept, 4);
        check("en_pops_total", n_pops, 1);
        check("en_fifo_left", fifo_q.size(), 1);
        check("en_late", late_flag, 1);
        check("en_first", first_cnt, 1012);

        // Reset after two of eight samples aborts the pulse.
        enable = 1'b1;
        fifo_q.delete();
        drive_head();
        do_reset();
        counter = 32'd2000;
        fifo_q.push_back(mk_entry(32'h0100_0000, 16'h1000, 16'h0321, 32'd1990, 16'd8, 10'h080));
        fifo_q.push_back(mk_entry(32'h0100_0000, 16'h3000, 16'h0654, 32'd2100, 16'd2, 10'h090));
        drive_head();
        for (int k = 0; k < 50 && n_accept < 2; k++) step();
        check("mid_accepts", n_accept, 2);
        check("mid_late", late_flag, 1);
        check("mid_busy", busy, 1);
        check("mid_fifo_left", fifo_q.size(), 1);
        do_reset();
        check("post_rst_fifo_left", fifo_q.size(), 1);
        run_until_idle(300);
        check("post_rst_done", pulses_done, 1);
        check("post_rst_accepts", n_accept, 2);
        check("post_rst_pops", n_pops, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
